glb_rdport_agu: RTL and testbench

// - Read-port address generator and return buffer placed directly upstream of one GLB read port.
// - Takes a job (base, count, stride) and issues count addresses on the GLB RdPortAddr handshake.
// - Captures GLB RdPortDat returns in a credit-protected FIFO and streams them to a compute consumer with a last flag.
// - One instance per GLB read port. The consumer never stalls the GLB data return beyond the FIFO depth.

---
 rtl/glb_pkg.sv | 14 +
 rtl/glb_rdport_agu_if.sv | 28 ++
 rtl/glb_sfifo.sv | 48 ++++
 rtl/glb_rdport_agu.sv | 137 +++++++++++++
 tb/tb_glb_rdport_agu.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/glb_pkg.sv
// Shared GLB definitions: read-port AGU state encoding.
package glb_pkg;

  localparam logic [1:0] AGU_IDLE  = 2'd0;
  localparam logic [1:0] AGU_ISSUE = 2'd1;
  localparam logic [1:0] AGU_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    AguIdle  = AGU_IDLE,
    AguIssue = AGU_ISSUE,
    AguDrain = AGU_DRAIN
  } agu_state_e;

endpackage

// File: rtl/glb_rdport_agu_if.sv
// GLB read-port handshakes plus the consumer stream, as seen by the read-port AGU.
interface glb_rdport_agu_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 256
);

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_addr_vld;
  logic                  rd_addr_rdy;
  logic [DATA_WIDTH-1:0] rd_dat;
  logic                  rd_dat_vld;
  logic                  rd_dat_rdy;
  logic [DATA_WIDTH-1:0] out_dat;
  logic                  out_vld;
  logic                  out_last;
  logic                  out_rdy;

  modport master (
    output rd_addr, rd_addr_vld, rd_dat_rdy, out_dat, out_vld, out_last,
    input  rd_addr_rdy, rd_dat, rd_dat_vld, out_rdy
  );

  modport slave (
    input  rd_addr, rd_addr_vld, rd_dat_rdy, out_dat, out_vld, out_last,
    output rd_addr_rdy, rd_dat, rd_dat_vld, out_rdy
  );

endinterface

// File: rtl/glb_sfifo.sv
// Synchronous FIFO with a registered-storage head; shared by GLB read and write ports.
module glb_sfifo #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/glb_rdport_agu.sv
// GLB read-port address generator with a credit-protected return FIFO feeding a consumer.
module glb_rdport_agu
  import glb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [LEN_WIDTH-1:0]  cfg_num,
  input  logic [ADDR_WIDTH-1:0] cfg_stride,
  output logic                  busy,
  output logic                  done,
  glb_rdport_agu_if.master      bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CreditMax = CW'(FIFO_DEPTH);

  agu_state_e            state_q, state_d;
  logic [LEN_WIDTH-1:0]  num_q, num_d;
  logic [LEN_WIDTH-1:0]  addr_cnt_q, addr_cnt_d;
  logic [LEN_WIDTH-1:0]  elem_cnt_q, elem_cnt_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  addr_vld_q, addr_vld_d;
  logic                  done_zero_q, done_zero_d;
  logic [CW-1:0]         credit_q, credit_d;
  logic                  addr_hs, out_hs, fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;

  assign addr_hs = addr_vld_q & bus.rd_addr_rdy;
  assign out_hs  = bus.out_vld & bus.out_rdy;

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    stride_d    = stride_q;
    addr_d      = addr_q;
    addr_vld_d  = addr_vld_q;
    addr_cnt_d  = addr_cnt_q + LEN_WIDTH'(addr_hs);
    elem_cnt_d  = elem_cnt_q + LEN_WIDTH'(out_hs);
    credit_d    = credit_q + CW'(addr_hs) - CW'(out_hs);
    done_zero_d = 1'b0;
    done        = done_zero_q;
    if (addr_hs) addr_d = addr_q + stride_q;

    unique case (state_q)
      AguIdle: begin
        if (cfg_start) begin
          if (cfg_num == '0) begin
            done_zero_d = 1'b1;
          end else begin
            state_d    = AguIssue;
            num_d      = cfg_num;
            stride_d   = cfg_stride;
            addr_d     = cfg_base;
            addr_cnt_d = '0;
            elem_cnt_d = '0;
            addr_vld_d = 1'b1;
          end
        end
      end
      AguIssue: begin
        if (addr_hs && (addr_cnt_d == num_q)) begin
          state_d    = AguDrain;
          addr_vld_d = 1'b0;
        end else if (!addr_vld_q || addr_hs) begin
          // Only present a new address if its credit slot is guaranteed.
          addr_vld_d = (credit_d < CreditMax);
        end
      end
      AguDrain: begin
        if (out_hs && (elem_cnt_d == num_q)) begin
          state_d = AguIdle;
          done    = 1'b1;
        end
      end
      default: state_d = AguIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= AguIdle;
      num_q       <= '0;
      stride_q    <= '0;
      addr_q      <= '0;
      addr_vld_q  <= 1'b0;
      addr_cnt_q  <= '0;
      elem_cnt_q  <= '0;
      credit_q    <= '0;
      done_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      stride_q    <= stride_d;
      addr_q      <= addr_d;
      addr_vld_q  <= addr_vld_d;
      addr_cnt_q  <= addr_cnt_d;
      elem_cnt_q  <= elem_cnt_d;
      credit_q    <= credit_d;
      done_zero_q <= done_zero_d;
    end
  end

  glb_sfifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_ret_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.rd_dat_vld & bus.rd_dat_rdy),
    .wdata (bus.rd_dat),
    .pop   (out_hs),
    .rdata (bus.out_dat),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.rd_addr     = addr_q;
  assign bus.rd_addr_vld = addr_vld_q;
  assign bus.rd_dat_rdy  = ~fifo_full;
  assign bus.out_vld     = ~fifo_empty;
  assign bus.out_last    = bus.out_vld & (elem_cnt_q == num_q - LEN_WIDTH'(1));
  assign busy            = (state_q != AguIdle);

  // Occupancy is a subset of the outstanding credit.
  a_credit_covers_fifo: assert property (@(posedge clk) disable iff (!rst_n)
    credit_q >= fifo_count);

endmodule

// File: tb/tb_glb_rdport_agu.sv
// Directed bench for glb_rdport_agu with a latency-1 GLB model and logging monitor.
module tb_glb_rdport_agu;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 256;
  localparam int unsigned LW = 16;
  localparam int unsigned FD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cfg_start;
  logic [AW-1:0] cfg_base;
  logic [LW-1:0] cfg_num;
  logic [AW-1:0] cfg_stride;
  logic          busy, done;

  glb_rdport_agu_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  glb_rdport_agu #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_start  (cfg_start),
    .cfg_base   (cfg_base),
    .cfg_num    (cfg_num),
    .cfg_stride (cfg_stride),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Monitor logs
  logic [AW-1:0] addr_log [64];
  int            addr_cyc [64];
  logic [DW-1:0] out_log  [64];
  logic          last_log [64];
  int            out_cyc  [64];
  int n_addr, n_out, n_done, n_vld, n_busy, done_cyc, issue_cyc, ovf;
  logic busy_after_done, prev_done;
  int stall_idx = -1;
  int stall_left = 0;
  int n_stall, stall_bad;
  logic [AW-1:0] stall_addr;

  function automatic logic [DW-1:0] glb_word(input logic [AW-1:0] a);
    return {16{a ^ 16'hA5A5}};
  endfunction

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // GLB model (latency 1, stall injection) and handshake logger.
  initial begin
    logic          hs;
    logic [AW-1:0] hs_addr;
    hs_addr = '0;
    bus.rd_addr_rdy = 1'b1;
    bus.rd_dat_vld  = 1'b0;
    bus.rd_dat      = '0;
    prev_done       = 1'b0;
    forever begin
      @(negedge clk);
      hs = 1'b0;
      if (rst_n) begin
        if (bus.rd_addr_vld) n_vld++;
        if (busy) n_busy++;
        if (prev_done) busy_after_done = busy;
        prev_done = done;
        if (done) begin
          n_done++;
          done_cyc = cyc;
        end
        if (n_addr == stall_idx && stall_left > 0 && (bus.rd_addr_vld || n_stall > 0)) begin
          bus.rd_addr_rdy = 1'b0;
          stall_left--;
          n_stall++;
          if (!bus.rd_addr_vld || bus.rd_addr !== stall_addr) stall_bad++;
        end else begin
          bus.rd_addr_rdy = 1'b1;
        end
        if (bus.rd_addr_vld && bus.rd_addr_rdy) begin
          hs = 1'b1;
          hs_addr = bus.rd_addr;
          if (n_addr < 64) begin
            addr_log[n_addr] = bus.rd_addr;
            addr_cyc[n_addr] = cyc;
          end
          n_addr++;
        end
        if (bus.out_vld && bus.out_rdy) begin
          if (n_out < 64) begin
            out_log[n_out]  = bus.out_dat;
            last_log[n_out] = bus.out_last;
            out_cyc[n_out]  = cyc;
          end
          n_out++;
        end
      end
      @(posedge clk);
      #1;
      if (hs && !bus.rd_dat_rdy) ovf++;
      bus.rd_dat_vld = hs;
      bus.rd_dat     = glb_word(hs_addr);
    end
  end

  task automatic clear_logs();
    n_addr = 0; n_out = 0; n_done = 0; n_vld = 0; n_busy = 0;
    done_cyc = -1; ovf = 0; busy_after_done = 1'bx;
    n_stall = 0; stall_bad = 0;
  endtask

  task automatic start_job(input logic [AW-1:0] base, input logic [LW-1:0] num,
                           input logic [AW-1:0] stride);
    cfg_base = base; cfg_num = num; cfg_stride = stride;
    cfg_start = 1'b1;
    issue_cyc = cyc;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (busy && i < budget);
    check_eq({tag, " idle_in_budget"}, DW'(busy), DW'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic check_job(input string tag, input logic [AW-1:0] base, input int num,
                           input logic [AW-1:0] stride);
    logic [AW-1:0] ea;
    check_eq({tag, " n_addr"}, DW'(n_addr), DW'(num));
    check_eq({tag, " n_out"}, DW'(n_out), DW'(num));
    check_eq({tag, " n_done"}, DW'(n_done), DW'(1));
    ea = base;
    for (int i = 0; i < num && i < 64; i++) begin
      check_eq($sformatf("%s addr%0d", tag, i), DW'(addr_log[i]), DW'(ea));
      check_eq($sformatf("%s dat%0d", tag, i), out_log[i], glb_word(ea));
      check_eq($sformatf("%s last%0d", tag, i), DW'(last_log[i]), DW'(i == num - 1));
      ea = ea + stride;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_start = 1'b0; cfg_base = '0; cfg_num = '0; cfg_stride = '0;
    bus.out_rdy = 1'b1;
    clear_logs();
    #2 rst_n = 1'b0;
    #20;
    check_eq("rst busy", DW'(busy), DW'(0));
    check_eq("rst done", DW'(done), DW'(0));
    check_eq("rst rd_addr_vld", DW'(bus.rd_addr_vld), DW'(0));
    check_eq("rst rd_addr", DW'(bus.rd_addr), DW'(0));
    check_eq("rst out_vld", DW'(bus.out_vld), DW'(0));
    check_eq("rst out_last", DW'(bus.out_last), DW'(0));
    check_eq("rst rd_dat_rdy", DW'(bus.rd_dat_rdy), DW'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic job
    clear_logs();
    start_job(16'h0010, 16'd4, 16'd1);
    wait_idle("basic", 50);
    check_job("basic", 16'h0010, 4, 16'd1);
    check_eq("basic addr_consecutive", DW'(addr_cyc[3] - addr_cyc[0]), DW'(3));
    check_eq("basic outs_consecutive", DW'(out_cyc[3] - out_cyc[0]), DW'(3));
    check_eq("basic done_with_last", DW'(done_cyc), DW'(out_cyc[3]));
    check_eq("basic busy_after_done", DW'(busy_after_done), DW'(0));

    // Stride with address wrap
    clear_logs();
    start_job(16'hFFFE, 16'd3, 16'd3);
    wait_idle("wrap", 50);
    check_job("wrap", 16'hFFFE, 3, 16'd3);
    check_eq("wrap addr1", DW'(addr_log[1]), DW'(16'h0001));
    check_eq("wrap addr2", DW'(addr_log[2]), DW'(16'h0004));

    // Consumer back-pressure
    clear_logs();
    bus.out_rdy = 1'b0;
    start_job(16'h0100, 16'd8, 16'd2);
    repeat (9) begin @(posedge clk); #1; end
    check_eq("bp n_addr_stalled", DW'(n_addr), DW'(FD));
    check_eq("bp n_out_stalled", DW'(n_out), DW'(0));
    check_eq("bp out_vld_held", DW'(bus.out_vld), DW'(1));
    check_eq("bp out_dat_held", bus.out_dat, glb_word(16'h0100));
    check_eq("bp rd_addr_vld_low", DW'(bus.rd_addr_vld), DW'(0));
    bus.out_rdy = 1'b1;
    wait_idle("bp", 100);
    check_job("bp", 16'h0100, 8, 16'd2);
    check_eq("bp overflow", DW'(ovf), DW'(0));

    // GLB address stall on the 2nd address
    clear_logs();
    stall_idx = 1; stall_left = 3; stall_addr = 16'h0044;
    start_job(16'h0040, 16'd5, 16'd4);
    wait_idle("stall", 100);
    check_job("stall", 16'h0040, 5, 16'd4);
    check_eq("stall cycles", DW'(n_stall), DW'(3));
    check_eq("stall held", DW'(stall_bad), DW'(0));
    stall_idx = -1;

    // Zero-length job
    clear_logs();
    start_job(16'h0123, 16'd0, 16'd1);
    repeat (3) begin @(posedge clk); #1; end
    check_eq("zero n_done", DW'(n_done), DW'(1));
    check_eq("zero done_cycle", DW'(done_cyc), DW'(issue_cyc + 1));
    check_eq("zero n_vld", DW'(n_vld), DW'(0));
    check_eq("zero n_busy", DW'(n_busy), DW'(0));

    // Start during ISSUE is ignored
    clear_logs();
    start_job(16'h0200, 16'd6, 16'd1);
    @(posedge clk); #1;
    start_job(16'h0999, 16'd2, 16'd5);
    wait_idle("ign", 60);
    check_job("ign", 16'h0200, 6, 16'd1);

    // Reset in the middle of a job
    clear_logs();
    start_job(16'h0300, 16'd6, 16'd1);
    for (int i = 0; i < 50 && n_out < 2; i++) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mrst n_out", DW'(n_out), DW'(2));
    check_eq("mrst busy", DW'(busy), DW'(0));
    check_eq("mrst done", DW'(done), DW'(0));
    check_eq("mrst rd_addr_vld", DW'(bus.rd_addr_vld), DW'(0));
    check_eq("mrst rd_addr", DW'(bus.rd_addr), DW'(0));
    check_eq("mrst out_vld", DW'(bus.out_vld), DW'(0));
    check_eq("mrst rd_dat_rdy", DW'(bus.rd_dat_rdy), DW'(1));
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("mrst no_done", DW'(n_done), DW'(0));
    check_eq("mrst out_vld_after", DW'(bus.out_vld), DW'(0));
    clear_logs();
    start_job(16'h0500, 16'd3, 16'd1);
    wait_idle("post", 50);
    check_job("post", 16'h0500, 3, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
